// File: rtl/frame_fifo_pkg.sv
// Shared definitions for the frame movers: state encoding, constants and
// the burst-length helper.
package frame_fifo_pkg;

    localparam logic [2:0] S_IDLE            = 3'd0;
    localparam logic [2:0] S_ACK             = 3'd1;
    localparam logic [2:0] S_CHECK_FIFO      = 3'd2;
    localparam logic [2:0] S_WRITE_BURST     = 3'd3;
    localparam logic [2:0] S_WRITE_BURST_END = 3'd4;
    localparam logic [2:0] S_END             = 3'd5;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    // Evaluated at 32 bits so the min() sees full-width counts before any truncation.
    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_fifo_write_sync.sv
// Parameterized multi-flop synchronizer for bringing request/length/index
// into the memory clock domain.
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/frame_fifo_write.sv
// Write-side frame mover: drains the video input FIFO into memory as a
// sequence of bursts, the last of which may be short.
module frame_fifo_write
    import frame_fifo_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10,
    parameter int BURST_SIZE    = 128
) (
    input  logic                  mem_clk,
    input  logic                  rst_n,
    output logic                  wr_burst_req,
    output logic [BURST_BITS-1:0] wr_burst_len,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    input  logic                  write_req,
    output logic                  write_req_ack,
    output logic                  write_finish,
    input  logic [ADDR_BITS-1:0]  write_addr_0,
    input  logic [ADDR_BITS-1:0]  write_addr_1,
    input  logic                  write_addr_index,
    input  logic [ADDR_BITS-1:0]  write_len,
    output logic                  fifo_aclr,
    input  logic [15:0]           rdusedw
);

    generate
        if (BURST_SIZE < 1 || BURST_SIZE >= (1 << BURST_BITS) || MEM_DATA_BITS < 1) begin : g_bad_params
            $error("frame_fifo_write: BURST_SIZE must be in [1, 2**BURST_BITS)");
        end
    endgenerate

    logic                 req_s;
    logic [ADDR_BITS-1:0] len_s;
    logic                 idx_s;

    sync_bus #(.WIDTH(1), .STAGES(3)) u_sync_req (
        .clk_i(mem_clk), .rst_ni(rst_n), .d_i(write_req), .q_o(req_s)
    );
    sync_bus #(.WIDTH(ADDR_BITS), .STAGES(2)) u_sync_len (
        .clk_i(mem_clk), .rst_ni(rst_n), .d_i(write_len), .q_o(len_s)
    );
    sync_bus #(.WIDTH(1), .STAGES(2)) u_sync_idx (
        .clk_i(mem_clk), .rst_ni(rst_n), .d_i(write_addr_index), .q_o(idx_s)
    );

    logic [2:0]            state_q, state_d;
    logic                  req_q, req_d;
    logic [BURST_BITS-1:0] blen_q, blen_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS-1:0]  len_latch_q, len_latch_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  remain;
    logic [31:0]           this_len;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        blen_d      = blen_q;
        addr_d      = addr_q;
        len_latch_d = len_latch_q;
        cnt_d       = cnt_q;
        remain      = len_latch_q - cnt_q;
        this_len    = min_len(32'(BURST_SIZE), 32'(remain));

        case (state_q)
            S_IDLE: begin
                if (req_s) state_d = S_ACK;
            end
            S_ACK: begin
                if (req_s) begin
                    addr_d      = idx_s ? write_addr_1 : write_addr_0;
                    len_latch_d = len_s;
                    cnt_d       = '0;
                end else begin
                    state_d = (len_latch_q == '0) ? S_END : S_CHECK_FIFO;
                end
            end
            S_CHECK_FIFO: begin
                if (req_s) begin
                    state_d = S_ACK;
                end else if (32'(rdusedw) >= this_len) begin
                    blen_d  = this_len[BURST_BITS-1:0];
                    req_d   = ONE;
                    state_d = S_WRITE_BURST;
                end
            end
            S_WRITE_BURST: begin
                if (wr_burst_data_req) req_d = ZERO;
                // Finish takes the transition even when it coincides with a data pull.
                if (wr_burst_finish) begin
                    cnt_d   = cnt_q + ADDR_BITS'(blen_q);
                    addr_d  = addr_q + ADDR_BITS'(blen_q);
                    state_d = S_WRITE_BURST_END;
                end
            end
            S_WRITE_BURST_END: begin
                if (req_s)                   state_d = S_ACK;
                else if (cnt_q < len_latch_q) state_d = S_CHECK_FIFO;
                else                         state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= ZERO;
            blen_q      <= '0;
            addr_q      <= '0;
            len_latch_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            blen_q      <= blen_d;
            addr_q      <= addr_d;
            len_latch_q <= len_latch_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wr_burst_req  = req_q;
    assign wr_burst_len  = blen_q;
    assign wr_burst_addr = addr_q;
    assign write_req_ack = (state_q == S_ACK) && req_s;
    assign fifo_aclr     = (state_q == S_ACK) && req_s;
    assign write_finish  = (state_q == S_END);

endmodule

// File: tb/tb_frame_fifo_write.sv
// Randomized scoreboard bench for frame_fifo_write with a behavioural
// memory-controller model and a per-frame burst reference model.
module tb_frame_fifo_write;

    logic        mem_clk = 1'b0;
    logic        rst_n;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [22:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic        write_req;
    logic        write_req_ack;
    logic        write_finish;
    logic [22:0] write_addr_0;
    logic [22:0] write_addr_1;
    logic        write_addr_index;
    logic [22:0] write_len;
    logic        fifo_aclr;
    logic [15:0] rdusedw;

    typedef struct packed {
        logic [22:0] addr;
        logic [9:0]  len;
    } burst_t;

    burst_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     ctl_hold = 1'b0;
    bit     rd_rand  = 1'b0;
    int     rd_fixed = 0;

    frame_fifo_write dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish(wr_burst_finish), .write_req(write_req),
        .write_req_ack(write_req_ack), .write_finish(write_finish),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_index(write_addr_index), .write_len(write_len),
        .fifo_aclr(fifo_aclr), .rdusedw(rdusedw)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is cut into full bursts from its base, with one short tail.
    function automatic void push_frame(input logic [22:0] base, input int len);
        int cnt = 0;
        while (cnt < len) begin
            int     l;
            burst_t b;
            l = (len - cnt > 128) ? 128 : len - cnt;
            b.addr = base + 23'(cnt);
            b.len  = 10'(l);
            exp_q.push_back(b);
            cnt += l;
        end
    endfunction

    initial begin
        rdusedw = '0;
        forever begin
            @(negedge mem_clk);
            rdusedw = rd_rand ? 16'($urandom_range(0, 200)) : 16'(rd_fixed);
        end
    end

    // Memory controller model: pulls len words, finish on last pull or one cycle later.
    initial begin
        int l, d;
        bit fin_same;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (!ctl_hold && rst_n === 1'b1 && wr_burst_req === 1'b1) begin
                l        = int'(wr_burst_len);
                d        = int'($urandom_range(0, 3));
                fin_same = 1'($urandom_range(0, 1));
                repeat (d) @(negedge mem_clk);
                for (int i = 0; i < l; i++) begin
                    wr_burst_data_req = 1'b1;
                    wr_burst_finish   = fin_same && (i == l - 1);
                    @(negedge mem_clk);
                end
                wr_burst_data_req = 1'b0;
                wr_burst_finish   = 1'b0;
                if (!fin_same) begin
                    wr_burst_finish = 1'b1;
                    @(negedge mem_clk);
                    wr_burst_finish = 1'b0;
                end
            end
        end
    end

    initial begin
        bit prev = 1'b0;
        burst_t b;
        forever begin
            @(posedge mem_clk);
            #1;
            if (rst_n !== 1'b1) begin
                prev = 1'b0;
            end else begin
                if (wr_burst_req && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_burst_req", 32'(wr_burst_addr), 32'hFFFF_FFFF);
                    end else begin
                        b = exp_q.pop_front();
                        check("burst_addr", 32'(wr_burst_addr), 32'(b.addr));
                        check("burst_len", 32'(wr_burst_len), 32'(b.len));
                    end
                end
                if (fifo_aclr || write_req_ack)
                    check("aclr_tracks_ack", 32'(fifo_aclr), 32'(write_req_ack));
                prev = wr_burst_req;
            end
        end
    end

    task automatic request_frame(input bit idx, input logic [22:0] a0, input logic [22:0] a1,
                                 input int len);
        int lat = 0;
        @(posedge mem_clk);
        #1;
        write_addr_0     = a0;
        write_addr_1     = a1;
        write_addr_index = idx;
        write_len        = 23'(len);
        write_req        = 1'b1;
        repeat (20) begin
            @(posedge mem_clk);
            #1;
            lat++;
            if (write_req_ack) break;
        end
        check("ack_latency", 32'(lat), 32'd4);
        check("aclr_at_ack", 32'(fifo_aclr), 32'd1);
        exp_q.delete();
        push_frame(idx ? a1 : a0, len);
        write_req = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge mem_clk);
            #1;
            if (write_finish) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_finish_seen"}, 32'(got), 32'd1);
        check({name, "_all_bursts_issued"}, 32'(exp_q.size()), 32'd0);
        @(posedge mem_clk);
        #1;
        check({name, "_finish_one_cycle"}, 32'(write_finish), 32'd0);
    endtask

    task automatic wait_queue_le(input int n);
        for (int i = 0; i < 3000; i++) begin
            @(posedge mem_clk);
            #1;
            if (exp_q.size() <= n) break;
        end
        check("queue_drain_bound", 32'(exp_q.size() <= n), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        write_req        = 1'b0;
        write_addr_0     = '0;
        write_addr_1     = '0;
        write_addr_index = 1'b0;
        write_len        = '0;
        rst_n            = 1'b0;
        repeat (3) @(posedge mem_clk);
        #1;
        check("rst_wr_burst_req", 32'(wr_burst_req), 32'd0);
        check("rst_wr_burst_len", 32'(wr_burst_len), 32'd0);
        check("rst_wr_burst_addr", 32'(wr_burst_addr), 32'd0);
        check("rst_write_req_ack", 32'(write_req_ack), 32'd0);
        check("rst_fifo_aclr", 32'(fifo_aclr), 32'd0);
        check("rst_write_finish", 32'(write_finish), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge mem_clk);

        // Basic two-burst frame
        rd_fixed = 200;
        request_frame(1'b0, 23'h000100, 23'h0, 256);
        wait_finish("basic");

        // Short tail issued with exactly enough words
        request_frame(1'b0, 23'h000000, 23'h0, 300);
        wait_queue_le(1);
        rd_fixed = 44;
        wait_finish("tail");

        // Starvation, then just enough data
        rd_fixed = 100;
        request_frame(1'b0, 23'h001000, 23'h0, 256);
        repeat (20) @(posedge mem_clk);
        #1;
        check("starved_no_req", 32'(wr_burst_req), 32'd0);
        rd_fixed = 128;
        @(posedge mem_clk);
        #1;
        check("starved_req_after_fill", 32'(wr_burst_req), 32'd1);
        wait_finish("starve");

        // Restart while waiting for data after the first burst
        rd_fixed = 200;
        request_frame(1'b0, 23'h000000, 23'h0, 512);
        wait_queue_le(3);
        rd_fixed = 0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge mem_clk);
            #1;
            if (wr_burst_finish) begin
                got = 1'b1;
                break;
            end
        end
        check("restart_first_burst_done", 32'(got), 32'd1);
        repeat (10) @(posedge mem_clk);
        request_frame(1'b1, 23'h000000, 23'h200000, 200);
        rd_fixed = 200;
        wait_finish("restart");

        // Zero length frame
        request_frame(1'b0, 23'h004000, 23'h0, 0);
        wait_finish("zero_len");

        // Reset in the middle of a burst
        ctl_hold = 1'b1;
        request_frame(1'b0, 23'h001000, 23'h0, 256);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge mem_clk);
            #1;
            if (wr_burst_req) begin
                got = 1'b1;
                break;
            end
        end
        check("reset_test_burst_started", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_burst_req", 32'(wr_burst_req), 32'd0);
        check("async_rst_wr_burst_addr", 32'(wr_burst_addr), 32'd0);
        check("async_rst_wr_burst_len", 32'(wr_burst_len), 32'd0);
        check("async_rst_write_finish", 32'(write_finish), 32'd0);
        repeat (2) @(posedge mem_clk);
        #1;
        exp_q.delete();
        rst_n    = 1'b1;
        ctl_hold = 1'b0;
        repeat (30) @(posedge mem_clk);
        #1;
        check("post_reset_idle_req", 32'(wr_burst_req), 32'd0);
        check("post_reset_idle_ack", 32'(write_req_ack), 32'd0);

        // Random frames with random FIFO fill and controller timing
        rd_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            logic [22:0] a0, a1;
            a0 = (f % 3 == 0) ? 23'h7FFFC0 : 23'($urandom);
            a1 = 23'($urandom);
            request_frame(1'($urandom_range(0, 1)), a0, a1, int'($urandom_range(0, 700)));
            wait_finish("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
